cp0_exc: RTL and testbench

- Coprocessor-0 exception responder in the M stage of the MIPS pipeline; consumes the exception code carried down from E/M stage logic.
- Holds SR, Cause, EPC and PRId, arbitrates hardware interrupts against the synchronous exception code, and raises a one-cycle handler request.
- Records the victim PC.
- Serves mfc0 reads and mtc0 writes, and clears EXL on eret.

---
 rtl/cp0_exc_pkg.sv | 54 +++++
 rtl/cp0_int_arb.sv | 28 ++
 rtl/cp0_exc.sv | 107 ++++++++++
 tb/tb_cp0_exc.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_exc_pkg.sv
// Shared CP0 definitions: exception codes, register numbers, SR/Cause field
// positions and helpers that assemble the architectural register words.
package cp0_exc_pkg;

  // Exception codes carried down the pipeline and recorded in Cause.ExcCode
  localparam logic [4:0] EXC_CODE_INT     = 5'd0;
  localparam logic [4:0] EXC_CODE_ADEL    = 5'd4;
  localparam logic [4:0] EXC_CODE_ADES    = 5'd5;
  localparam logic [4:0] EXC_CODE_RI      = 5'd10;
  localparam logic [4:0] EXC_CODE_OV      = 5'd12;
  localparam logic [4:0] EXC_CODE_DEFAULT = 5'd31;

  // CP0 register numbers
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR field positions
  localparam int SR_IM_HI = 15;
  localparam int SR_IM_LO = 10;
  localparam int SR_EXL   = 1;
  localparam int SR_IE    = 0;

  // Cause field positions
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_EXC_LO = 2;

  // Assemble SR from its implemented fields; unimplemented bits read 0
  function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                          input logic ie);
    logic [31:0] w;
    w                    = '0;
    w[SR_IM_HI:SR_IM_LO] = im;
    w[SR_EXL]            = exl;
    w[SR_IE]             = ie;
    return w;
  endfunction

  // Assemble Cause from its implemented fields; unimplemented bits read 0
  function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] exc_code);
    logic [31:0] w;
    w                              = '0;
    w[CAUSE_BD]                    = bd;
    w[CAUSE_IP_HI:CAUSE_IP_LO]     = ip;
    w[CAUSE_EXC_HI:CAUSE_EXC_LO]   = exc_code;
    return w;
  endfunction

endpackage

// File: rtl/cp0_int_arb.sv
// Interrupt/exception arbiter: decides whether the M-stage instruction is
// taken away to the handler this cycle and which ExcCode gets recorded.
module cp0_int_arb
  import cp0_exc_pkg::*;
(
  input  logic [5:0] ip,
  input  logic [5:0] im,
  input  logic       ie,
  input  logic       exl,
  input  logic [4:0] exc_code_m,
  output logic       int_req,
  output logic [4:0] next_exc_code
);

  logic irq;
  logic exc;

  // Everything is masked while the handler runs (EXL=1)
  assign irq = (|(ip & im)) & ie & ~exl;
  assign exc = (exc_code_m != EXC_CODE_DEFAULT) & ~exl;

  assign int_req = irq | exc;

  // A pending interrupt outranks the synchronous exception; the faulting
  // instruction simply re-executes after eret.
  assign next_exc_code = irq ? EXC_CODE_INT : exc_code_m;

endmodule

// File: rtl/cp0_exc.sv
// Coprocessor-0 exception responder in the M stage: holds SR, Cause, EPC and
// PRId, raises the handler request, records the victim PC and serves
// mfc0/mtc0/eret.
module cp0_exc
  import cp0_exc_pkg::*;
#(
  parameter logic [31:0] PRID    = 32'h4C57_0001,
  parameter logic [31:0] HANDLER = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PCM,
  input  logic        BDM,
  input  logic [6:2]  ExcCodeM,
  input  logic        EXLClr,
  input  logic [7:2]  HWInt,
  output logic        IntReq,
  output logic [31:0] HandlerPC,
  output logic [31:0] EPC,
  output logic [31:0] DOut
);

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc_q;
  logic [4:0]  next_exc_code;
  logic [31:0] pc_word;
  logic [31:0] victim_pc;

  cp0_int_arb u_arb (
    .ip            (cause_ip),
    .im            (sr_im),
    .ie            (sr_ie),
    .exl           (sr_exl),
    .exc_code_m    (ExcCodeM),
    .int_req       (IntReq),
    .next_exc_code (next_exc_code)
  );

  // A delay-slot victim resumes at its branch, one word earlier
  assign pc_word   = {PCM[31:2], 2'b00};
  assign victim_pc = BDM ? (pc_word - 32'd4) : pc_word;

  // Instructions are word aligned, so the PC byte offset carries no information
  logic unused_pcm_bits;
  assign unused_pcm_bits = ^PCM[1:0];

  assign HandlerPC = HANDLER;
  assign EPC       = epc_q;

  // CP0 state: exception entry has priority over eret and mtc0
  // NOTE: state registers use non-blocking assignments so every read in this
  // block sees the pre-edge value, matching real flip-flop behaviour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_im     <= 6'h3F;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b1;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= EXC_CODE_INT;
      epc_q     <= '0;
    end else begin
      cause_ip <= HWInt;
      if (IntReq) begin
        sr_exl    <= 1'b1;
        cause_bd  <= BDM;
        cause_exc <= next_exc_code;
        epc_q     <= victim_pc;
      end else begin
        if (WE && (A2 == REG_SR)) begin
          sr_im  <= DIn[SR_IM_HI:SR_IM_LO];
          sr_ie  <= DIn[SR_IE];
          sr_exl <= DIn[SR_EXL] & ~EXLClr;
        end else if (EXLClr) begin
          sr_exl <= 1'b0;
        end
        if (WE && (A2 == REG_EPC)) begin
          epc_q <= {DIn[31:2], 2'b00};
        end
      end
    end
  end

  // mfc0 read port: pre-edge register contents, no write bypass
  // NOTE: DOut gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    DOut = '0;
    case (A1)
      REG_SR:    DOut = pack_sr(sr_im, sr_exl, sr_ie);
      REG_CAUSE: DOut = pack_cause(cause_bd, cause_ip, cause_exc);
      REG_EPC:   DOut = epc_q;
      REG_PRID:  DOut = PRID;
      default:   DOut = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc.sv
// Self-checking bench for cp0_exc: a word-level reference model compared on
// every falling edge, plus directed scenarios with literal expectations.
module tb_cp0_exc;

  localparam logic [31:0] PRID    = 32'h4C57_0001;
  localparam logic [31:0] HANDLER = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PCM;
  logic        BDM;
  logic [6:2]  ExcCodeM;
  logic        EXLClr;
  logic [7:2]  HWInt;
  logic        IntReq;
  logic [31:0] HandlerPC, EPC, DOut;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #10 clk = ~clk;

  cp0_exc #(.PRID(PRID), .HANDLER(HANDLER)) dut (
    .clk       (clk),
    .reset     (reset),
    .A1        (A1),
    .A2        (A2),
    .DIn       (DIn),
    .WE        (WE),
    .PCM       (PCM),
    .BDM       (BDM),
    .ExcCodeM  (ExcCodeM),
    .EXLClr    (EXLClr),
    .HWInt     (HWInt),
    .IntReq    (IntReq),
    .HandlerPC (HandlerPC),
    .EPC       (EPC),
    .DOut      (DOut)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole 32-bit register words, updated by the rules
  logic [31:0] m_sr, m_cause, m_epc;

  function automatic logic m_irq();
    return ((m_cause[15:10] & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_exc();
    return (ExcCodeM != 5'd31) && !m_sr[1];
  endfunction

  function automatic logic m_take();
    return m_irq() || m_exc();
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sr    <= 32'h0000_FC01;
      m_cause <= 32'd0;
      m_epc   <= 32'd0;
    end else if (m_take()) begin
      m_sr    <= m_sr | 32'h2;
      m_cause <= ({31'd0, BDM} << 31) | ({26'd0, HWInt} << 10)
               | ({27'd0, (m_irq() ? 5'd0 : ExcCodeM)} << 2);
      m_epc   <= (PCM & ~32'h3) - (BDM ? 32'd4 : 32'd0);
    end else begin
      m_cause <= (m_cause & ~32'h0000_FC00) | ({26'd0, HWInt} << 10);
      if (WE && A2 == 5'd12)
        m_sr <= DIn & (EXLClr ? 32'h0000_FC01 : 32'h0000_FC03);
      else if (EXLClr)
        m_sr <= m_sr & ~32'h2;
      if (WE && A2 == 5'd14)
        m_epc <= DIn & ~32'h3;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_intreq",  {31'd0, IntReq}, {31'd0, m_take()});
      check("cmp_dout",    DOut, m_read(A1));
      check("cmp_epc",     EPC, m_epc);
      check("cmp_handler", HandlerPC, HANDLER);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic eret();
    EXLClr = 1'b1;
    cyc();
    EXLClr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; A1 = 5'd12; A2 = 5'd0; DIn = '0; WE = 1'b0; PCM = '0;
    BDM = 1'b0; ExcCodeM = 5'd31; EXLClr = 1'b0; HWInt = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cmp_en = 1'b1;

    // Reset state
    #1 check("rst_sr", DOut, 32'h0000_FC01);
    A1 = 5'd13;
    #1 check("rst_cause", DOut, 32'd0);
    check("rst_epc", EPC, 32'd0);
    check("rst_intreq", {31'd0, IntReq}, 32'd0);
    check("handler_pc", HandlerPC, 32'h0000_4180);

    // Overflow outside a delay slot
    ExcCodeM = 5'd12; PCM = 32'h0000_3010;
    #1 check("ov_intreq", {31'd0, IntReq}, 32'd1);
    cyc();
    ExcCodeM = 5'd31; PCM = '0;
    #1 check("ov_epc", EPC, 32'h0000_3010);
    A1 = 5'd13;
    #1 check("ov_cause", DOut, 32'h0000_0030);
    A1 = 5'd12;
    #1 check("ov_sr", DOut, 32'h0000_FC03);
    ExcCodeM = 5'd12;
    #1 check("ov_masked", {31'd0, IntReq}, 32'd0);
    ExcCodeM = 5'd31;
    eret();
    #1 check("eret_sr", DOut, 32'h0000_FC01);

    // Delay-slot AdEL colliding with an mtc0 EPC write
    ExcCodeM = 5'd4; PCM = 32'h0000_3008; BDM = 1'b1;
    WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_DEAD;
    #1 check("bd_intreq", {31'd0, IntReq}, 32'd1);
    cyc();
    ExcCodeM = 5'd31; PCM = '0; BDM = 1'b0; WE = 1'b0; DIn = '0;
    #1 check("bd_epc", EPC, 32'h0000_3004);
    A1 = 5'd13;
    #1 check("bd_cause", DOut, 32'h8000_0010);
    eret();

    // Interrupt beats a same-cycle exception
    HWInt = 6'b000001; PCM = 32'h0000_3020;
    #1 check("irq_not_yet", {31'd0, IntReq}, 32'd0);
    cyc();
    ExcCodeM = 5'd5;
    #1 check("irq_intreq", {31'd0, IntReq}, 32'd1);
    cyc();
    ExcCodeM = 5'd12;
    #1 check("irq_cause", DOut, 32'h0000_0400);
    check("irq_epc", EPC, 32'h0000_3020);
    check("irq_masked", {31'd0, IntReq}, 32'd0);
    ExcCodeM = 5'd31; HWInt = '0;
    eret();
    #1 check("eret2_intreq", {31'd0, IntReq}, 32'd0);

    // Interrupt mask via mtc0 SR, and eret colliding with an SR write
    A1 = 5'd12; HWInt = 6'b000001;
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
    cyc();
    WE = 1'b0;
    #1 check("mask_intreq", {31'd0, IntReq}, 32'd1);
    #1 check("mask_sr", DOut, 32'h0000_0401);
    cyc();
    EXLClr = 1'b1; WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0402;
    #1 check("coll_intreq", {31'd0, IntReq}, 32'd0);
    cyc();
    EXLClr = 1'b0; WE = 1'b0;
    #1 check("coll_sr", DOut, 32'h0000_0400);
    check("ie_off_intreq", {31'd0, IntReq}, 32'd0);

    // Writes to Cause and PRId are ignored
    WE = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
    cyc();
    A2 = 5'd15;
    cyc();
    WE = 1'b0; A1 = 5'd13;
    #1 check("ro_cause", DOut, 32'h0000_0400);
    A1 = 5'd15;
    #1 check("prid", DOut, 32'h4C57_0001);
    A1 = 5'd7;
    #1 check("unimpl_reg", DOut, 32'd0);

    // mtc0 EPC aligns the value; reads show the pre-edge value
    A1 = 5'd14; WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_3007;
    #1 check("epc_no_bypass", DOut, 32'h0000_3020);
    cyc();
    WE = 1'b0;
    #1 check("epc_write", DOut, 32'h0000_3004);

    // Reset in the middle of a handler
    HWInt = '0; ExcCodeM = 5'd10; PCM = 32'h0000_3040; A1 = 5'd12;
    cyc();
    ExcCodeM = 5'd31;
    #1 check("ri_sr", DOut, 32'h0000_0402);
    #1 reset = 1'b1;
    #1 check("mid_rst_sr", DOut, 32'h0000_FC01);
    check("mid_rst_epc", EPC, 32'd0);
    check("mid_rst_intreq", {31'd0, IntReq}, 32'd0);
    A1 = 5'd13;
    #1 check("mid_rst_cause", DOut, 32'd0);
    cyc();
    reset = 1'b0;
    cyc();
    cyc();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
